temp_count_dp: RTL
==================

// Module: temp_count_dp
// PURPOSE
//  Timer datapath driven by the Temp_uc control unit: consumes Ld/CE, returns RC.
//  Holds a loadable down-counter in "time units" derived from Ck via an internal
//  prescaler. RC flags expiry of the programmed interval, e.g. irrigation duration.
//  Sits between the timer control unit and the preset source (switches/registers).
// PARAMETERS
//  WIDTH      8   counter/preset width in bits
//  PRESC_DIV  10  Ck cycles per time unit (>=2); prescaler width = $clog2(PRESC_DIV)
// PORTS
//  Ck    in   1      clock, rising edge
//  Clr   in   1      asynchronous reset, active-low
//  Ld    in   1      load preset D into counter (from control unit)
//  CE    in   1      count enable (from control unit); 0 = pause
//  D     in   WIDTH  preset interval in time units
//  Q     out  WIDTH  remaining time units
//  Tick  out  1      one-cycle pulse on every time-unit boundary while counting
//  RC    out  1      interval expired (to control unit)
// BEHAVIOUR
//  - Reset (Clr=0, async): state=IDLE, Q=0, prescaler=0, Tick=0, RC=0. All outputs registered.
//  - FSM states: IDLE, RUN, DONE. IDLE/DONE ignore CE.
//  - Ld=1 (any state, priority over CE): Q<=D, prescaler<=0, Tick<=0;
//    state<=RUN, RC<=0 if D!=0; state<=DONE, RC<=1 if D==0.
//  - RUN, CE=1: prescaler increments; when prescaler==PRESC_DIV-1: prescaler<=0,
//    Tick<=1 for one cycle, Q<=Q-1; if Q==1 then state<=DONE, RC<=1 on the same edge Q becomes 0.
//  - RUN, CE=0: Q and prescaler hold; Tick=0 (pause, no loss of partial unit).
//  - DONE: Q holds 0 (never wraps); RC stays 1 until Ld or reset.
//  - Latency: Ld of N (N>0) with CE held high -> RC rises N*PRESC_DIV edges after the Ld edge.
//  - Each CE-low cycle in RUN delays RC by exactly one cycle.
//  - Reset mid-count aborts immediately; no state survives.
// CONFIGURATION
//  TEMP_RELOAD_EN defined: periodic mode. On Ld, D is also latched into preset register P.
//    In RUN, when Q==1 at a unit boundary: Q<=P, state stays RUN, RC pulses for one cycle
//    (Q never shows 0). Period = P*PRESC_DIV cycles. Ld with D==0 still goes to DONE (RC held).
//  TEMP_RELOAD_EN undefined: one-shot as above. No P register exists.
// STRUCTURE
//  Package temp_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} temp_state_t;
//    localparams for default WIDTH and PRESC_DIV shared with Temp_uc benches.
//  Sub-module temp_prescaler (Ck, Clr, clr_cnt, en, tc): modulo-PRESC_DIV counter;
//    tc=1 when count==PRESC_DIV-1 and en=1. The FSM, Q and RC stay in temp_count_dp.
// TESTING  (WIDTH=8, PRESC_DIV=4, TCK=100ns)
//  1 Clr=0 pulse during RUN with Q=5 -> Q=0, RC=0, Tick=0 immediately, without waiting for Ck.
//  2 Ld D=3, then CE=1 continuously -> Tick at edges 4,8,12; Q 3,2,1,0; RC=1 from edge 12, held.
//  3 Ld D=2, CE=1 except 5 cycles low after edge 3 -> RC rises at edge 13; Q steady while CE=0.
//  4 Ld D=0 -> next edge state DONE, RC=1, Q=0, no Tick; CE=1 afterwards changes nothing.
//  5 RUN with Q=2, Ld=1 with D=5 and CE=1 in the same cycle -> Q=5, prescaler=0, RC=0.
//  6 TEMP_RELOAD_EN, Ld D=2, CE=1 -> RC 1-cycle pulses at edges 8,16,24; Q sequence 2,1,2,1.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and default sizing for the timer datapath and its control-unit benches.
package temp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} temp_state_t;

    localparam int unsigned TEMP_WIDTH     = 8;
    localparam int unsigned TEMP_PRESC_DIV = 10;

endpackage

// File: rtl/temp_prescaler.sv
// Modulo-PRESC_DIV cycle counter; tc marks the last cycle of a time unit while enabled.
module temp_prescaler #(
    parameter int unsigned PRESC_DIV = 10
) (
    input  logic Ck,
    input  logic Clr,
    input  logic clr_cnt,
    input  logic en,
    output logic tc
);

    localparam int unsigned PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tc    = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/temp_count_dp.sv
// Loadable down-counter in prescaled time units with expiry flag RC.
// Define TEMP_RELOAD_EN for periodic mode (reload from latched preset instead of stopping).
module temp_count_dp
    import temp_pkg::*;
#(
    parameter int unsigned WIDTH     = TEMP_WIDTH,
    parameter int unsigned PRESC_DIV = TEMP_PRESC_DIV
) (
    input  logic             Ck,
    input  logic             Clr,
    input  logic             Ld,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tick,
    output logic             RC
);

    temp_state_t      state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             rc_q, rc_d;
    logic             presc_en_c;
    logic             presc_tc_c;
`ifdef TEMP_RELOAD_EN
    logic [WIDTH-1:0] p_q, p_d;
`endif

    // Load has priority, so the prescaler only advances on genuine counting cycles.
    assign presc_en_c = (state_q == RUN) && CE && !Ld;

    temp_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .Ck      (Ck),
        .Clr     (Clr),
        .clr_cnt (Ld),
        .en      (presc_en_c),
        .tc      (presc_tc_c)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tick_d  = 1'b0;
        rc_d    = rc_q;
`ifdef TEMP_RELOAD_EN
        p_d     = p_q;
`endif
        if (Ld) begin
            q_d = D;
`ifdef TEMP_RELOAD_EN
            p_d = D;
`endif
            if (D != '0) begin
                state_d = RUN;
                rc_d    = 1'b0;
            end else begin
                state_d = DONE;
                rc_d    = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
`ifdef TEMP_RELOAD_EN
                    rc_d = 1'b0;
`endif
                    if (presc_tc_c) begin
                        tick_d = 1'b1;
                        if (q_q == WIDTH'(1)) begin
`ifdef TEMP_RELOAD_EN
                            q_d  = p_q;
                            rc_d = 1'b1;
`else
                            q_d     = '0;
                            state_d = DONE;
                            rc_d    = 1'b1;
`endif
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            tick_q  <= 1'b0;
            rc_q    <= 1'b0;
`ifdef TEMP_RELOAD_EN
            p_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tick_q  <= tick_d;
            rc_q    <= rc_d;
`ifdef TEMP_RELOAD_EN
            p_q     <= p_d;
`endif
        end
    end

    assign Q    = q_q;
    assign Tick = tick_q;
    assign RC   = rc_q;

endmodule
